// File: rtl/taxi_stats_tx_pkg.sv
// rtl/taxi_stats_tx_pkg.sv - shared types, widths and saturating add for the stat transmitter
package taxi_stats_tx_pkg;

  localparam int ACC_W = 16;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Returns {overflow, result}; result clamps at all-ones when the true sum does not fit.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
  endfunction

endpackage

// File: rtl/taxi_stats_tx_if.sv
// rtl/taxi_stats_tx_if.sv - ID-tagged stream interface carrying stat-increment words
interface taxi_axis_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, output tvalid, output tid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tid, input tuser, output tready);
endinterface

// File: rtl/taxi_stats_tx_acc.sv
// rtl/taxi_stats_tx_acc.sv - one channel's saturating accumulator with capture-clear
module taxi_stats_tx_acc
  import taxi_stats_tx_pkg::*;
#(
  parameter int INC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc_i,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = sat_add(acc_q, ACC_W'(inc_i));
    acc_d = sum[ACC_W-1:0];
    ovf_o = 1'b0;
    // Capturing cycle restarts from this cycle's increment so nothing is lost.
    if (clear_i) begin
      acc_d = ACC_W'(inc_i);
    end else begin
      ovf_o = sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/taxi_stats_tx.sv
// rtl/taxi_stats_tx.sv - per-channel stat accumulators drained as ID-tagged increment words
// Optional saturation counter port stat_ovf_count enabled by TAXI_STATS_TX_OVF_EN.
module taxi_stats_tx
  import taxi_stats_tx_pkg::*;
#(
  parameter int CNT           = 4,
  parameter int INC_W         = 8,
  parameter int ID_BASE       = 0,
  parameter int UPDATE_PERIOD = 1024,
  parameter int ID_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT*INC_W-1:0] stat_inc,
  taxi_axis_if.master          m_axis_stat
`ifdef TAXI_STATS_TX_OVF_EN
  ,
  output logic [31:0]          stat_ovf_count
`endif
);

  localparam int PTR_W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [0:0] S_SCAN = SCAN;
  localparam logic [0:0] S_HOLD = HOLD;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT-1:0]   flush_q, flush_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tvalid_q, tvalid_d;
  logic [ACC_W-1:0] tdata_q, tdata_d;
  logic [ID_W-1:0]  tid_q, tid_d;

  logic [ACC_W-1:0] acc_w [CNT];
  logic [CNT-1:0]   clear_w;
  logic [CNT-1:0]   ovf_w;
  logic             wrap;
  logic             eligible;

  for (genvar g = 0; g < CNT; g++) begin : g_chan
    taxi_stats_tx_acc #(
      .INC_W (INC_W)
    ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (stat_inc[g*INC_W +: INC_W]),
      .clear_i (clear_w[g]),
      .acc_o   (acc_w[g]),
      .ovf_o   (ovf_w[g])
    );
  end

  always_comb begin
    wrap    = (UPDATE_PERIOD != 0) && (timer_q == TMR_W'(UPDATE_PERIOD - 1));
    timer_d = (wrap || UPDATE_PERIOD == 0) ? '0 : timer_q + 1'b1;
  end

  assign eligible = (acc_w[ptr_q] != '0) && (acc_w[ptr_q][ACC_W-1] || flush_q[ptr_q]);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    flush_d  = flush_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    clear_w  = '0;
    if (wrap) begin
      flush_d = '1;
    end
    case (state_q)
      S_SCAN: begin
        // Visit clear comes after the wrap set so the visited channel misses this flush.
        flush_d[ptr_q] = 1'b0;
        ptr_d = (ptr_q == PTR_W'(CNT - 1)) ? '0 : ptr_q + 1'b1;
        if (eligible) begin
          tdata_d        = acc_w[ptr_q];
          tid_d          = ID_W'(ID_BASE) + ID_W'(ptr_q);
          tvalid_d       = 1'b1;
          clear_w[ptr_q] = 1'b1;
          state_d        = S_HOLD;
        end
      end
      default: begin
        if (m_axis_stat.tready) begin
          tvalid_d = 1'b0;
          state_d  = S_SCAN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SCAN;
      ptr_q    <= '0;
      flush_q  <= '0;
      timer_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      flush_q  <= flush_d;
      timer_q  <= timer_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
    end
  end

  assign m_axis_stat.tvalid = tvalid_q;
  assign m_axis_stat.tdata  = tdata_q;
  assign m_axis_stat.tid    = tid_q;
  assign m_axis_stat.tuser  = '0;

`ifdef TAXI_STATS_TX_OVF_EN
  logic [31:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    for (int i = 0; i < CNT; i++) begin
      ovf_cnt_d = ovf_cnt_d + 32'(ovf_w[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign stat_ovf_count = ovf_cnt_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf_w;
`endif

endmodule

// File: tb/tb_taxi_stats_tx.sv
// tb/tb_taxi_stats_tx.sv - directed checks of the stat transmitter (periodic and non-periodic instances)
module tb_taxi_stats_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inc_a = '0;
  logic [31:0] inc_b = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [23:0] qa[$];
  logic [23:0] qb[$];

  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(16), .ID_W(8), .USER_W(1)) axis_a ();
  taxi_axis_if #(.DATA_W(16), .ID_W(8), .USER_W(1)) axis_b ();

`ifdef TAXI_STATS_TX_OVF_EN
  logic [31:0] ovf_a, ovf_b;
`endif

  taxi_stats_tx #(.CNT(4), .INC_W(8), .ID_BASE(3), .UPDATE_PERIOD(64), .ID_W(8)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .stat_inc       (inc_a),
    .m_axis_stat    (axis_a)
`ifdef TAXI_STATS_TX_OVF_EN
    ,
    .stat_ovf_count (ovf_a)
`endif
  );

  taxi_stats_tx #(.CNT(4), .INC_W(8), .ID_BASE(0), .UPDATE_PERIOD(0), .ID_W(8)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .stat_inc       (inc_b),
    .m_axis_stat    (axis_b)
`ifdef TAXI_STATS_TX_OVF_EN
    ,
    .stat_ovf_count (ovf_b)
`endif
  );

  always @(posedge clk) begin
    if (!rst && axis_a.tvalid && axis_a.tready) qa.push_back({axis_a.tid, axis_a.tdata});
    if (!rst && axis_b.tvalid && axis_b.tready) qb.push_back({axis_b.tid, axis_b.tdata});
  end

  task automatic reset_duts();
    @(negedge clk);
    rst = 1'b1;
    inc_a = '0;
    inc_b = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    axis_a.tready = 1'b1;
    axis_b.tready = 1'b1;
    reset_duts();
    n_checks++; if (axis_a.tvalid !== 1'b0) $display("FAIL reset_tvalid_a: got %0b expected 0", axis_a.tvalid); else n_pass++;
    n_checks++; if (axis_a.tdata !== 16'd0) $display("FAIL reset_tdata_a: got %0d expected 0", axis_a.tdata); else n_pass++;
    n_checks++; if (axis_a.tid !== 8'd0) $display("FAIL reset_tid_a: got %0d expected 0", axis_a.tid); else n_pass++;
    n_checks++; if (axis_a.tuser !== 1'b0) $display("FAIL reset_tuser_a: got %0b expected 0", axis_a.tuser); else n_pass++;
    n_checks++; if (axis_b.tvalid !== 1'b0) $display("FAIL reset_tvalid_b: got %0b expected 0", axis_b.tvalid); else n_pass++;
`ifdef TAXI_STATS_TX_OVF_EN
    n_checks++; if (ovf_a !== 32'd0) $display("FAIL reset_ovf_a: got %0d expected 0", ovf_a); else n_pass++;
`endif
  endtask

  task automatic test_flush();
    reset_duts();
    axis_a.tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      inc_a = (k % 2 == 0) ? 32'h0000_0500 : 32'h0;
      @(negedge clk);
    end
    inc_a = '0;
    repeat (55) @(negedge clk);
    n_checks++; if (qa.size() != 0) $display("FAIL flush_early_words: got %0d expected 0", qa.size()); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++; if (qa.size() != 1) $display("FAIL flush_word_count: got %0d expected 1", qa.size()); else n_pass++;
    if (qa.size() >= 1) begin
      n_checks++; if (qa[0] !== {8'd4, 16'd15}) $display("FAIL flush_word: got tid %0d data %0d expected tid 4 data 15", qa[0][23:16], qa[0][15:0]); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] exp_w [4];
    exp_w[0] = {8'd3, 16'd11};
    exp_w[1] = {8'd4, 16'd22};
    exp_w[2] = {8'd5, 16'd33};
    exp_w[3] = {8'd6, 16'd44};
    reset_duts();
    axis_a.tready = 1'b1;
    inc_a = {8'd44, 8'd33, 8'd22, 8'd11};
    @(negedge clk);
    inc_a = '0;
    repeat (150) @(negedge clk);
    n_checks++; if (qa.size() != 4) $display("FAIL rr_count: got %0d expected 4", qa.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (qa.size() > i) begin
        n_checks++;
        if (qa[i] !== exp_w[i]) $display("FAIL rr_word%0d: got tid %0d data %0d expected tid %0d data %0d", i, qa[i][23:16], qa[i][15:0], exp_w[i][23:16], exp_w[i][15:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_capture_race();
    int w_cnt;
    int w_sum;
    int w0;
    int w1;
    reset_duts();
    axis_a.tready = 1'b1;
    for (int k = 0; k < 132; k++) begin
      inc_a = (k < 131) ? 32'hff00_0000 : 32'h0700_0000;
      @(negedge clk);
    end
    inc_a = '0;
    repeat (150) @(negedge clk);
    w_cnt = 0; w_sum = 0; w0 = 0; w1 = 0;
    foreach (qa[i]) begin
      if (qa[i][23:16] == 8'd6) begin
        if (w_cnt == 0) w0 = int'(qa[i][15:0]);
        if (w_cnt == 1) w1 = int'(qa[i][15:0]);
        w_cnt++;
        w_sum += int'(qa[i][15:0]);
      end
    end
    n_checks++; if (w_cnt != 2) $display("FAIL race_count: got %0d expected 2", w_cnt); else n_pass++;
    n_checks++; if (w0 < 32768) $display("FAIL race_first_urgent: got %0d expected >= 32768", w0); else n_pass++;
    n_checks++; if (w1 != 7) $display("FAIL race_second: got %0d expected 7", w1); else n_pass++;
    n_checks++; if (w_sum != 33412) $display("FAIL race_sum: got %0d expected 33412", w_sum); else n_pass++;
  endtask

  task automatic test_urgent();
    int tid0_cnt;
    reset_duts();
    axis_b.tready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      inc_b = (k == 0) ? 32'h00c8_0001 : 32'h00c8_0000;
      @(negedge clk);
    end
    inc_b = '0;
    repeat (10) @(negedge clk);
    tid0_cnt = 0;
    foreach (qb[i]) if (qb[i][23:16] == 8'd0) tid0_cnt++;
    n_checks++; if (qb.size() != 1) $display("FAIL urgent_count: got %0d expected 1", qb.size()); else n_pass++;
    n_checks++; if (tid0_cnt != 0) $display("FAIL urgent_no_periodic: got %0d expected 0", tid0_cnt); else n_pass++;
    if (qb.size() >= 1) begin
      n_checks++; if (qb[0][23:16] !== 8'd2) $display("FAIL urgent_tid: got %0d expected 2", qb[0][23:16]); else n_pass++;
      n_checks++;
      if (qb[0][15:0] < 16'd32768 || qb[0][15:0] > 16'd33400) $display("FAIL urgent_data: got %0d expected 32768..33400", qb[0][15:0]);
      else n_pass++;
    end
  endtask

  task automatic test_conservation();
    int ch2_sum;
    reset_duts();
    axis_a.tready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      inc_a = 32'h00c8_0000;
      @(negedge clk);
    end
    for (int r = 0; r < 3; r++) begin
      inc_a = 32'h0000_0001;
      @(negedge clk);
      inc_a = '0;
      repeat (140) @(negedge clk);
    end
    ch2_sum = 0;
    foreach (qa[i]) if (qa[i][23:16] == 8'd5) ch2_sum += int'(qa[i][15:0]);
    n_checks++; if (ch2_sum != 80000) $display("FAIL conserve_sum: got %0d expected 80000", ch2_sum); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] held_data;
    logic [7:0]  held_id;
    bit          seen;
    int          unstable;
    reset_duts();
    axis_a.tready = 1'b0;
    seen = 1'b0; unstable = 0; held_data = '0; held_id = '0;
    for (int k = 0; k < 500; k++) begin
      inc_a = 32'h0000_00ff;
      @(negedge clk);
      if (!seen && axis_a.tvalid) begin
        seen = 1'b1;
        held_data = axis_a.tdata;
        held_id = axis_a.tid;
      end else if (seen && (axis_a.tvalid !== 1'b1 || axis_a.tdata !== held_data || axis_a.tid !== held_id)) begin
        unstable++;
      end
    end
    inc_a = '0;
    n_checks++; if (seen !== 1'b1) $display("FAIL bp_word_seen: got %0b expected 1", seen); else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); else n_pass++;
    n_checks++; if (held_data !== 16'd16320) $display("FAIL bp_held_data: got %0d expected 16320", held_data); else n_pass++;
`ifdef TAXI_STATS_TX_OVF_EN
    n_checks++; if (ovf_a !== 32'd179) $display("FAIL bp_ovf_count: got %0d expected 179", ovf_a); else n_pass++;
`endif
    axis_a.tready = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (qa.size() != 2) $display("FAIL bp_count: got %0d expected 2", qa.size()); else n_pass++;
    if (qa.size() >= 2) begin
      n_checks++; if (qa[0] !== {8'd3, 16'd16320}) $display("FAIL bp_first: got tid %0d data %0d expected tid 3 data 16320", qa[0][23:16], qa[0][15:0]); else n_pass++;
      n_checks++; if (qa[1] !== {8'd3, 16'hffff}) $display("FAIL bp_saturated: got tid %0d data %0d expected tid 3 data 65535", qa[1][23:16], qa[1][15:0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    bit seen;
    reset_duts();
    axis_a.tready = 1'b0;
    seen = 1'b0;
    inc_a = 32'h0000_6400;
    @(negedge clk);
    for (int k = 0; k < 200 && !seen; k++) begin
      inc_a = 32'h0009_0000;
      @(negedge clk);
      if (axis_a.tvalid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL hold_reached: got %0b expected 1", seen); else n_pass++;
    n_checks++; if ({axis_a.tid, axis_a.tdata} !== {8'd4, 16'd100}) $display("FAIL hold_word: got tid %0d data %0d expected tid 4 data 100", axis_a.tid, axis_a.tdata); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inc_a = '0;
    n_checks++; if (axis_a.tvalid !== 1'b0) $display("FAIL hold_reset_tvalid: got %0b expected 0", axis_a.tvalid); else n_pass++;
    qa.delete();
    axis_a.tready = 1'b1;
    repeat (150) @(negedge clk);
    n_checks++; if (qa.size() != 0) $display("FAIL hold_reset_discard: got %0d words expected 0", qa.size()); else n_pass++;
  endtask

  initial begin
    axis_a.tready = 1'b0;
    axis_b.tready = 1'b0;
    test_reset();
    test_flush();
    test_round_robin();
    test_capture_race();
    test_urgent();
    test_conservation();
    test_backpressure();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected completion within 500000 time units");
    $fatal(1);
  end

endmodule
